drift_adjust_scheduler: RTL and testbench
=========================================

Name: drift_adjust_scheduler

Overview:
- Shares the single phase-adjust port of the recovered-clock generator between the two drift requesters produced by drift tracking: expected-clock drift and preemptive-clock drift.
- Arbitrates round-robin between them and runs a req/res handshake towards the generator.
- Enforces a configurable lockout, counted in valid edges, between applied adjustments.
- Aborts a stalled adjustment after a configurable cycle timeout.

Parameters:
- LOCKOUT_WIDTH, 8, width of the lockout edge count and its counter (the top level ties it to clks_alot_p::DRIFT_COUNTER_WIDTH).
- TIMEOUT_WIDTH, 8, width of the handshake timeout count and its counter.

Ports:
- sys_dom_i  in  common_p::clk_dom_s  system clock domain: one clock (.clk); reset (.rst_n) is asynchronous and active-low.
- scheduler_en_i  in  1  permits new grants.
- clear_state_i  in  1  synchronous abort and flush.
- any_valid_edge_i  in  1  one-cycle pulse per valid sampled edge.
- lockout_edges_i  in  LOCKOUT_WIDTH  valid edges to wait after an adjustment; 0 means no lockout.
- timeout_cycles_i  in  TIMEOUT_WIDTH  maximum cycles to wait for adj_res_i; 0 means no timeout.
- expected_drift_req_i  in  1  request level from the expected-clock requester.
- expected_drift_direction_i  in  clks_alot_p::drift_direction_e  direction for that request.
- expected_drift_res_o  out  1  one-cycle completion pulse to the expected-clock requester.
- preemptive_drift_req_i  in  1  request level from the preemptive-clock requester.
- preemptive_drift_direction_i  in  clks_alot_p::drift_direction_e  direction for that request.
- preemptive_drift_res_o  out  1  one-cycle completion pulse to the preemptive-clock requester.
- adj_req_o  out  1  adjustment request level to the generator.
- adj_res_i  in  1  one-cycle acknowledge from the generator.
- adj_direction_o  out  clks_alot_p::drift_direction_e  latched direction of the granted request.
- adj_target_o  out  1  granted target: 0 = expected clock, 1 = preemptive clock.
- adj_timeout_o  out  1  sticky flag: a handshake timed out.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: all outputs 0; adj_direction_o takes the enum's zero encoding; state IDLE; counters 0; last_grant = preemptive, so expected wins the first tie.
- States and transitions:
  - IDLE -> ISSUE when scheduler_en_i is high and at least one unmasked request is pending.
  - ISSUE -> RESPOND when adj_res_i is seen.
  - ISSUE -> IDLE on timeout.
  - RESPOND -> LOCKOUT when lockout_edges_i != 0, otherwise RESPOND -> IDLE.
  - LOCKOUT -> IDLE after the programmed number of edges.
- Arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the one not equal to last_grant.
  - Target and direction are latched at the grant and stay stable until ISSUE exits.
  - last_grant updates at every grant.
- Latency:
  - adj_req_o rises in the cycle after the IDLE grant decision.
  - adj_req_o falls in the cycle after adj_res_i.
  - The matching *_res_o pulses exactly once, in the RESPOND cycle, i.e. 1 cycle after adj_res_i.
- Requester rule: the requester drops req in the cycle after its res_o pulse. In the first IDLE cycle after RESPOND, the scheduler masks the served requester so a late-falling req is not double-granted.
- Lockout:
  - Counter loads lockout_edges_i on entering LOCKOUT.
  - It decrements on each any_valid_edge_i pulse.
  - Exit to IDLE occurs on the edge that takes the count from 1 to 0.
  - An edge coincident with the RESPOND cycle is not counted.
  - New requests wait (are not lost) during lockout.
- Timeout:
  - A cycle counter clears on entering ISSUE and increments each ISSUE cycle.
  - If timeout_cycles_i != 0 and the count reaches timeout_cycles_i with no adj_res_i, then:
    - adj_req_o drops;
    - adj_timeout_o sets;
    - the state returns to IDLE with no res_o;
    - the requester stays pending and re-arbitrates with last_grant already advanced.
  - adj_res_i in the same cycle as the timeout: the response wins and the timeout is not flagged.
- scheduler_en_i low:
  - Blocks only IDLE grants.
  - An in-flight ISSUE, RESPOND or LOCKOUT completes normally.
  - The lockout counter keeps counting.
- clear_state_i (highest priority, synchronous):
  - Next cycle: state IDLE, adj_req_o 0, no res_o, counters 0, last_grant = preemptive, adj_timeout_o cleared.
  - An adj_res_i arriving after the clear is ignored.
- Async reset mid-handshake: everything returns to reset values immediately, with no res_o.
- adj_res_i outside ISSUE is ignored.
- Counters never wrap: lockout saturates at 0, timeout stops at the limit.

Test Plan:
- Both reqs high from reset, lockout 0, generator acks 3 cycles after adj_req_o -> expected granted first (adj_target_o=0), then preemptive; each res_o is a single pulse 1 cycle after its adj_res_i; no double grant.
- lockout_edges_i=3, expected req re-raised right after its res -> no adj_req_o until the 3rd any_valid_edge_i after RESPOND; the edge in the RESPOND cycle is not counted; adj_req_o rises the cycle after the lockout exits.
- timeout_cycles_i=5, generator never acks -> adj_req_o high for exactly 5 cycles, then drops; adj_timeout_o=1 and stays 1; no res_o; the request is re-issued next; ack on the 5th cycle instead -> normal res_o and adj_timeout_o stays 0.
- clear_state_i pulsed in ISSUE, followed by a late adj_res_i -> adj_req_o=0 next cycle; no res_o; adj_timeout_o cleared; the late ack is ignored; next tie grants expected.
- scheduler_en_i low with a pending req -> no grant; raise enable -> grant the next cycle; drop enable during ISSUE -> the transaction still completes with res_o.
- Async reset asserted while adj_req_o=1 -> all outputs 0 immediately; after release, a pending request is re-granted from IDLE with expected priority.

Source files
------------

// File: rtl/drift_adjust_scheduler.sv
// Round-robin scheduler that shares the recovered-clock generator's single
// phase-adjust port between the expected- and preemptive-clock drift requesters.
`timescale 1ns/1ps

package common_p;
  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;
endpackage

package clks_alot_p;
  localparam int DRIFT_COUNTER_WIDTH = 8;
  typedef enum logic {
    DRIFT_RETARD  = 1'b0,
    DRIFT_ADVANCE = 1'b1
  } drift_direction_e;
endpackage

module drift_adjust_scheduler #(
  parameter int LOCKOUT_WIDTH = clks_alot_p::DRIFT_COUNTER_WIDTH,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  common_p::clk_dom_s            sys_dom_i,
  input  logic                          scheduler_en_i,
  input  logic                          clear_state_i,
  input  logic                          any_valid_edge_i,
  input  logic [LOCKOUT_WIDTH-1:0]      lockout_edges_i,
  input  logic [TIMEOUT_WIDTH-1:0]      timeout_cycles_i,
  input  logic                          expected_drift_req_i,
  input  clks_alot_p::drift_direction_e expected_drift_direction_i,
  output logic                          expected_drift_res_o,
  input  logic                          preemptive_drift_req_i,
  input  clks_alot_p::drift_direction_e preemptive_drift_direction_i,
  output logic                          preemptive_drift_res_o,
  output logic                          adj_req_o,
  input  logic                          adj_res_i,
  output clks_alot_p::drift_direction_e adj_direction_o,
  output logic                          adj_target_o,
  output logic                          adj_timeout_o,
  output logic                          busy_o,
  output logic [1:0]                    dbg_state_o
);

  // Handshake: adj_req_o is a level held from the grant until the cycle after
  // adj_res_i (a one-cycle pulse); the requester then sees a one-cycle *_res_o.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  localparam logic TGT_EXP = 1'b0;
  localparam logic TGT_PRE = 1'b1;

  logic clk;
  logic rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  state_e                        state_q, state_d;
  logic                          last_grant_q, last_grant_d;
  logic                          target_q, target_d;
  clks_alot_p::drift_direction_e dir_q, dir_d;
  logic                          timeout_q, timeout_d;
  logic                          mask_q, mask_d;
  logic [LOCKOUT_WIDTH-1:0]      lock_cnt_q, lock_cnt_d;
  logic [TIMEOUT_WIDTH-1:0]      wait_cnt_q, wait_cnt_d;

  logic                          pend_exp, pend_pre, grant_pre, timeout_hit;
  logic [TIMEOUT_WIDTH:0]        wait_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= TGT_PRE;
      target_q     <= TGT_EXP;
      dir_q        <= clks_alot_p::DRIFT_RETARD;
      timeout_q    <= 1'b0;
      mask_q       <= 1'b0;
      lock_cnt_q   <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      target_q     <= target_d;
      dir_q        <= dir_d;
      timeout_q    <= timeout_d;
      mask_q       <= mask_d;
      lock_cnt_q   <= lock_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    target_d     = target_q;
    dir_d        = dir_q;
    timeout_d    = timeout_q;
    mask_d       = 1'b0;
    lock_cnt_d   = lock_cnt_q;
    wait_cnt_d   = wait_cnt_q;

    // The requester just served may still show req for one cycle; hide it.
    pend_exp    = expected_drift_req_i && !(mask_q && target_q == TGT_EXP);
    pend_pre    = preemptive_drift_req_i && !(mask_q && target_q == TGT_PRE);
    grant_pre   = (pend_exp && pend_pre) ? ~last_grant_q : pend_pre;
    wait_next   = {1'b0, wait_cnt_q} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1};
    timeout_hit = (timeout_cycles_i != '0) && (wait_next >= {1'b0, timeout_cycles_i});

    if (clear_state_i) begin
      state_d      = IDLE;
      last_grant_d = TGT_PRE;
      target_d     = TGT_EXP;
      dir_d        = clks_alot_p::DRIFT_RETARD;
      timeout_d    = 1'b0;
      lock_cnt_d   = '0;
      wait_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (scheduler_en_i && (pend_exp || pend_pre)) begin
            state_d      = ISSUE;
            target_d     = grant_pre;
            last_grant_d = grant_pre;
            dir_d        = grant_pre ? preemptive_drift_direction_i : expected_drift_direction_i;
            wait_cnt_d   = '0;
          end
        end
        ISSUE: begin
          // A response in the timeout cycle still completes normally.
          if (adj_res_i) begin
            state_d = RESPOND;
          end else if (timeout_hit) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + TIMEOUT_WIDTH'(1);
          end
        end
        RESPOND: begin
          if (lockout_edges_i != '0) begin
            state_d    = LOCKOUT;
            lock_cnt_d = lockout_edges_i;
          end else begin
            state_d = IDLE;
            mask_d  = 1'b1;
          end
        end
        LOCKOUT: begin
          if (any_valid_edge_i) begin
            if (lock_cnt_q <= LOCKOUT_WIDTH'(1)) begin
              lock_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              lock_cnt_d = lock_cnt_q - LOCKOUT_WIDTH'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign adj_req_o              = (state_q == ISSUE);
  assign expected_drift_res_o   = (state_q == RESPOND) && (target_q == TGT_EXP);
  assign preemptive_drift_res_o = (state_q == RESPOND) && (target_q == TGT_PRE);
  assign adj_direction_o        = dir_q;
  assign adj_target_o           = target_q;
  assign adj_timeout_o          = timeout_q;
  assign busy_o                 = (state_q != IDLE);
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_drift_adjust_scheduler.sv
// Randomized bench for drift_adjust_scheduler: behavioural model of the
// sharing rules, per-cycle output checks and a grant scoreboard.
`timescale 1ns/1ps

module tb_drift_adjust_scheduler;
  import clks_alot_p::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  common_p::clk_dom_s sys_dom;
  assign sys_dom = '{clk: clk, rst_n: rst_n};

  logic             scheduler_en_i, clear_state_i, any_valid_edge_i;
  logic [7:0]       lockout_edges_i, timeout_cycles_i;
  logic             expected_drift_req_i, preemptive_drift_req_i;
  drift_direction_e expected_drift_direction_i, preemptive_drift_direction_i;
  logic             expected_drift_res_o, preemptive_drift_res_o;
  logic             adj_req_o, adj_res_i, adj_target_o, adj_timeout_o, busy_o;
  drift_direction_e adj_direction_o;
  logic [1:0]       dbg_state_o;

  drift_adjust_scheduler #(.LOCKOUT_WIDTH(8), .TIMEOUT_WIDTH(8)) dut (
    .sys_dom_i                    (sys_dom),
    .scheduler_en_i               (scheduler_en_i),
    .clear_state_i                (clear_state_i),
    .any_valid_edge_i             (any_valid_edge_i),
    .lockout_edges_i              (lockout_edges_i),
    .timeout_cycles_i             (timeout_cycles_i),
    .expected_drift_req_i         (expected_drift_req_i),
    .expected_drift_direction_i   (expected_drift_direction_i),
    .expected_drift_res_o         (expected_drift_res_o),
    .preemptive_drift_req_i       (preemptive_drift_req_i),
    .preemptive_drift_direction_i (preemptive_drift_direction_i),
    .preemptive_drift_res_o       (preemptive_drift_res_o),
    .adj_req_o                    (adj_req_o),
    .adj_res_i                    (adj_res_i),
    .adj_direction_o              (adj_direction_o),
    .adj_target_o                 (adj_target_o),
    .adj_timeout_o                (adj_timeout_o),
    .busy_o                       (busy_o),
    .dbg_state_o                  (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];   // {target, direction} of each predicted grant
  logic prev_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_req: adjustment outstanding at the generator; m_resp: requester being
  // completed this cycle (-1 none); m_edges_left: edges still to wait out;
  // m_skip: requester hidden from the next arbitration (-1 none).
  bit m_req, m_tgt, m_dir, m_last, m_to;
  int m_age, m_resp, m_edges_left, m_skip;

  task automatic model_reset();
    m_req = 0; m_tgt = 0; m_dir = 0; m_last = 1; m_to = 0;
    m_age = 0; m_resp = -1; m_edges_left = 0; m_skip = -1;
  endtask

  task automatic model_step();
    int skip;
    bit want_e, want_p;
    if (clear_state_i) begin
      model_reset();
      return;
    end
    skip = m_skip;
    m_skip = -1;
    if (m_req) begin
      if (adj_res_i) begin
        m_req = 0;
        m_resp = int'(m_tgt);
      end else if (timeout_cycles_i != 0 && m_age + 1 >= int'(timeout_cycles_i)) begin
        m_req = 0;
        m_to = 1;
      end else begin
        m_age++;
      end
    end else if (m_resp >= 0) begin
      if (lockout_edges_i != 0) m_edges_left = int'(lockout_edges_i);
      else m_skip = m_resp;
      m_resp = -1;
    end else if (m_edges_left > 0) begin
      if (any_valid_edge_i) m_edges_left--;
    end else if (scheduler_en_i) begin
      want_e = expected_drift_req_i && skip != 0;
      want_p = preemptive_drift_req_i && skip != 1;
      if (want_e || want_p) begin
        m_tgt  = (want_e && want_p) ? !m_last : want_p;
        m_last = m_tgt;
        m_dir  = m_tgt ? preemptive_drift_direction_i : expected_drift_direction_i;
        m_req  = 1;
        m_age  = 0;
        exp_q.push_back({m_tgt, m_dir});
      end
    end
  endtask

  // ---------------- driver ----------------
  bit req_lv[2];
  bit dir_lv[2];
  int drop_cnt[2];
  int gen_age = 0, gen_delay = 1;
  bit gen_never = 0;
  int k_req_pct, k_edge_pct, k_en_low_pct, k_clear_pm, k_spur_pct;
  int k_ack_min, k_ack_max, k_never_pct, k_rst_pm;
  bit k_soak;
  int cur_lock, cur_tmo;

  task automatic drive_inputs();
    bit seen[2];
    seen[0] = expected_drift_res_o;
    seen[1] = preemptive_drift_res_o;
    // Requesters keep req up one cycle past res_o, then drop it.
    for (int i = 0; i < 2; i++) begin
      if (seen[i]) begin
        drop_cnt[i] = 2;
      end else if (drop_cnt[i] > 0) begin
        drop_cnt[i]--;
        if (drop_cnt[i] == 0) req_lv[i] = 0;
      end else if (!req_lv[i] && $urandom_range(0, 99) < k_req_pct) begin
        req_lv[i] = 1;
        dir_lv[i] = 1'($urandom_range(0, 1));
      end
    end
    expected_drift_req_i         = req_lv[0];
    expected_drift_direction_i   = drift_direction_e'(dir_lv[0]);
    preemptive_drift_req_i       = req_lv[1];
    preemptive_drift_direction_i = drift_direction_e'(dir_lv[1]);
    any_valid_edge_i = ($urandom_range(0, 99) < k_edge_pct);
    scheduler_en_i   = ($urandom_range(0, 99) >= k_en_low_pct);
    clear_state_i    = ($urandom_range(0, 999) < k_clear_pm);
    if (k_soak) begin
      if ($urandom_range(0, 99) < 3) cur_lock = $urandom_range(0, 4);
      if (!m_req && $urandom_range(0, 99) < 5) cur_tmo = $urandom_range(0, 8);
    end
    lockout_edges_i  = 8'(cur_lock);
    timeout_cycles_i = 8'(cur_tmo);
    // Generator: ack after a random delay, or never when a timeout is armed.
    if (adj_req_o) begin
      gen_age++;
      if (gen_age == 1) begin
        gen_never = (cur_tmo != 0) && ($urandom_range(0, 99) < k_never_pct);
        gen_delay = $urandom_range(k_ack_min, k_ack_max);
      end
      adj_res_i = !gen_never && (gen_age == gen_delay);
    end else begin
      gen_age = 0;
      adj_res_i = ($urandom_range(0, 99) < k_spur_pct);
    end
  endtask

  task automatic compare();
    check("adj_req", adj_req_o, m_req);
    if (m_req) begin
      check("adj_target", adj_target_o, m_tgt);
      check("adj_direction", adj_direction_o, m_dir);
    end
    check("expected_res", expected_drift_res_o, m_resp == 0);
    check("preemptive_res", preemptive_drift_res_o, m_resp == 1);
    check("adj_timeout", adj_timeout_o, m_to);
    check("busy", busy_o, m_req || m_resp >= 0 || m_edges_left > 0);
    if (adj_req_o && !prev_req) begin
      check("grant_scheduled", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("grant_select", {adj_target_o, adj_direction_o}, exp_q.pop_front());
    end
    prev_req = adj_req_o;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_adj_req"}, adj_req_o, 0);
    check({tag, "_expected_res"}, expected_drift_res_o, 0);
    check({tag, "_preemptive_res"}, preemptive_drift_res_o, 0);
    check({tag, "_adj_timeout"}, adj_timeout_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_adj_target"}, adj_target_o, 0);
    check({tag, "_adj_direction"}, adj_direction_o, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    prev_req = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_inputs();
    model_step();
    @(posedge clk);
    #1;
    compare();
    if (k_rst_pm > 0 && adj_req_o && $urandom_range(0, 999) < k_rst_pm) begin
      #2;
      apply_reset("mid_rst");
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    scheduler_en_i = 0; clear_state_i = 0; any_valid_edge_i = 0;
    lockout_edges_i = 0; timeout_cycles_i = 0; adj_res_i = 0;
    expected_drift_req_i = 0; preemptive_drift_req_i = 0;
    expected_drift_direction_i = DRIFT_RETARD; preemptive_drift_direction_i = DRIFT_RETARD;
    for (int i = 0; i < 2; i++) begin req_lv[i] = 0; dir_lv[i] = 0; drop_cnt[i] = 0; end
    model_reset();
    #3;
    apply_reset("reset");

    // Both requesters always pending, fixed ack delay, no lockout/timeout.
    k_req_pct = 100; k_edge_pct = 30; k_en_low_pct = 0; k_clear_pm = 0; k_spur_pct = 0;
    k_ack_min = 3; k_ack_max = 3; k_never_pct = 0; k_rst_pm = 0; k_soak = 0;
    cur_lock = 0; cur_tmo = 0;
    repeat (200) cycle();

    // Lockout of 3 edges.
    cur_lock = 3; k_req_pct = 60; k_edge_pct = 40; k_ack_min = 1; k_ack_max = 4;
    repeat (400) cycle();

    // Timeout of 5 cycles; acks on the 5th cycle race the timeout.
    cur_lock = 0; cur_tmo = 5; k_never_pct = 50; k_ack_min = 1; k_ack_max = 6;
    repeat (400) cycle();

    // Enable gating, clears and stray acks.
    cur_lock = 2; k_en_low_pct = 40; k_clear_pm = 30; k_spur_pct = 10;
    repeat (400) cycle();

    // Mixed soak including asynchronous resets mid-handshake.
    k_soak = 1; k_req_pct = 40; k_en_low_pct = 15; k_clear_pm = 8; k_spur_pct = 8;
    k_ack_min = 1; k_ack_max = 8; k_never_pct = 30; k_rst_pm = 20;
    repeat (3000) cycle();

    check("grant_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
